ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_fifo.sv | 69 ++++++
 rtl/ifu.sv | 120 ++++++++++++
 tb/tb_ifu.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared core definitions for the instruction fetch unit: FSM encoding and boot address.
package ifu_pkg;

    localparam int unsigned IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight PC queue and the instruction buffer.
module ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Flush wins over any push/pop in the same cycle; push at full is legal only alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch with redirect flush and stale-response drain.
module ifu
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC),
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     pcq_count, ifq_count;
    logic [CW-1:0]     outstanding_c, out_next_c;
    logic [XLEN-1:0]   pcq_pc;
    logic [2*XLEN-1:0] ifq_data;
    logic              req_fire_c, rsp_keep_c, inst_pop_c;

    // In RUN every outstanding request owns a PC queue slot; in DRAIN they are all counted by drop_q.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        outstanding_c = (state_q == ST_DRAIN) ? drop_q : pcq_count;
        req_valid     = (state_q == ST_RUN) &&
                        ((SW'(outstanding_c) + SW'(ifq_count)) < SW'(DEPTH));
        req_fire_c    = req_valid && req_ready;
        rsp_keep_c    = rsp_valid && (state_q == ST_RUN) && (drop_q == '0) && !redirect_valid;
        inst_valid    = (ifq_count != '0);
        inst_pop_c    = inst_valid && inst_ready;
        out_next_c    = outstanding_c + CW'(req_fire_c) - CW'(rsp_valid);

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (req_fire_c) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            ST_DRAIN: begin
                if (rsp_valid) begin
                    drop_d = drop_q - CW'(1);
                    if (drop_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Everything in flight at a redirect, including this cycle's request, is old-path.
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            drop_d  = out_next_c;
            state_d = (out_next_c != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire_c),
        .push_data (pc_q),
        .pop       (rsp_keep_c),
        .pop_data  (pcq_pc),
        .count     (pcq_count)
    );

    ifu_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep_c),
        .push_data ({pcq_pc, rsp_data}),
        .pop       (inst_pop_c),
        .pop_data  (ifq_data),
        .count     (ifq_count)
    );

    assign req_addr = pc_q;
    assign inst     = ifq_data[XLEN-1:0];
    assign inst_pc  = ifq_data[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: queue-based fetch model checked every cycle plus literal scenario checks.
module tb_ifu;

    localparam int DEPTH = 2;
    localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory side
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          rsp_en;
    int          lat = 1;
    int          rsp_cnt = 0;
    logic [31:0] fire_log[$];
    logic [31:0] inst_pc_log[$];
    logic [31:0] inst_log[$];

    // reference model
    int          m_state;
    logic [31:0] m_pc;
    int          m_out;
    int          m_drop;
    logic [31:0] m_pq[$];
    logic [31:0] m_iq_pc[$];
    logic [31:0] m_iq_data[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h0F0F_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_req_valid();
        return (m_state == M_RUN) && ((m_out + m_iq_pc.size()) < DEPTH);
    endfunction

    task automatic m_reset();
        m_state = M_BOOT;
        m_pc    = 32'h8000_0000;
        m_out   = 0;
        m_drop  = 0;
        m_pq.delete();
        m_iq_pc.delete();
        m_iq_data.delete();
    endtask

    task automatic m_update();
        bit rfire, ifire;
        int nxt;
        rfire = m_req_valid() && req_ready;
        ifire = (m_iq_pc.size() > 0) && inst_ready;
        if (!rst) begin
            m_reset();
        end else if (redirect_valid) begin
            nxt = m_out + int'(rfire) - int'(rsp_valid);
            m_pq.delete();
            m_iq_pc.delete();
            m_iq_data.delete();
            m_out   = nxt;
            m_drop  = nxt;
            m_pc    = redirect_pc & ~32'h3;
            m_state = (nxt != 0) ? M_DRAIN : M_RUN;
        end else if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (ifire) begin
                void'(m_iq_pc.pop_front());
                void'(m_iq_data.pop_front());
            end
            if (rsp_valid && m_pq.size() > 0) begin
                m_iq_pc.push_back(m_pq.pop_front());
                m_iq_data.push_back(rsp_data);
                m_out--;
            end
            if (rfire) begin
                m_pq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end else begin
            if (rsp_valid) begin
                m_drop--;
                m_out--;
                if (m_drop == 0) m_state = M_RUN;
            end
        end
    endtask

    task automatic compare();
        bit mv;
        mv = m_req_valid();
        chk("req_valid", 32'(req_valid), 32'(mv));
        if (mv) chk("req_addr", req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_iq_pc.size() > 0));
        if (m_iq_pc.size() > 0) begin
            chk("inst_pc", inst_pc, m_iq_pc[0]);
            chk("inst", inst, m_iq_data[0]);
        end
    endtask

    // One clock: drive response, sample handshakes, advance model, then compare after the edge.
    task automatic step();
        if (rst && rsp_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(pend_addr.pop_front());
            void'(pend_due.pop_front());
            rsp_cnt++;
            chk("rsp_protocol_outstanding", 32'(m_out > 0), 32'd1);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        if (rst && req_valid && req_ready) begin
            pend_addr.push_back(req_addr);
            pend_due.push_back(cyc + lat);
            fire_log.push_back(req_addr);
        end
        if (rst && inst_valid && inst_ready) begin
            inst_pc_log.push_back(inst_pc);
            inst_log.push_back(inst);
        end
        m_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_en         = 1'b0;
        lat            = 1;
        pend_addr.delete();
        pend_due.delete();
        fire_log.delete();
        inst_pc_log.delete();
        inst_log.delete();
        m_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_fires(input int n, input int limit);
        int k = 0;
        while (fire_log.size() < n && k < limit) begin
            step();
            k++;
        end
        chk("wait_fires", 32'(fire_log.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int n0;
        int k;
        bit saw_inst;

        rst = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 32'h0;

        // Reset release, streaming fetch
        do_reset();
        chk("boot_req_valid", 32'(req_valid), 32'd0);
        chk("boot_inst_valid", 32'(inst_valid), 32'd0);
        req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        step();
        chk("first_req_valid", 32'(req_valid), 32'd1);
        chk("first_req_addr", req_addr, 32'h8000_0000);
        for (int i = 0; i < 8; i++) step();
        chk("fire0", fire_log[0], 32'h8000_0000);
        chk("fire1", fire_log[1], 32'h8000_0004);
        chk("fire2", fire_log[2], 32'h8000_0008);
        chk("inst_pc0", inst_pc_log[0], 32'h8000_0000);
        chk("inst0", inst_log[0], 32'h8F0F_0F0F);
        chk("inst_pc1", inst_pc_log[1], 32'h8000_0004);

        // IDU stalled: credit caps requests at DEPTH
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("credit_fires", 32'(fire_log.size()), 32'd2);
        chk("credit_hold", 32'(req_valid), 32'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("credit_release", 32'(req_valid), 32'd1);

        // Redirect with two outstanding
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1;
        wait_fires(2, 10);
        chk("two_out_req_valid", 32'(req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        chk("drain_req_valid", 32'(req_valid), 32'd0);
        rsp_en = 1'b1;
        rc0 = rsp_cnt;
        saw_inst = 1'b0;
        k = 0;
        while (fire_log.size() < 3 && k < 10) begin
            step();
            if (inst_valid) saw_inst = 1'b1;
            k++;
        end
        chk("stale_dropped", 32'(rsp_cnt - rc0), 32'd2);
        chk("redirect_addr", fire_log[2], 32'h8000_0100);
        chk("no_stale_inst", 32'(saw_inst), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("redirect_inst_pc", inst_pc_log[0], 32'h8000_0100);

        // Redirect coinciding with a response and a request fire
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1;
        wait_fires(1, 10);
        rsp_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        step();
        redirect_valid = 1'b0; rsp_en = 1'b0;
        chk("same_cycle_fire_logged", 32'(fire_log.size()), 32'd2);
        chk("same_cycle_drain", 32'(req_valid), 32'd0);
        chk("same_cycle_inst", 32'(inst_valid), 32'd0);
        step();
        chk("drain_hold", 32'(req_valid), 32'd0);
        rsp_en = 1'b1;
        step();
        chk("drop_one_req_valid", 32'(req_valid), 32'd1);
        chk("drop_one_req_addr", req_addr, 32'h0000_1000);
        chk("drop_one_no_inst", 32'(inst_valid), 32'd0);

        // Redirect in BOOT and PC wrap
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("boot_redirect_addr", req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) step();
        chk("wrap_fire0", fire_log[0], 32'hFFFF_FFFC);
        chk("wrap_fire1", fire_log[1], 32'h0000_0000);

        // Reset asserted during DRAIN
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1;
        wait_fires(2, 10);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_drain_req_valid", 32'(req_valid), 32'd0);
        chk("rst_drain_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_drain_req_addr", req_addr, 32'h8000_0000);
        m_reset();
        pend_addr.delete();
        pend_due.delete();
        step();
        rst = 1'b1;
        rsp_en = 1'b1;
        step();
        chk("restart_req_valid", 32'(req_valid), 32'd1);
        chk("restart_req_addr", req_addr, 32'h8000_0000);

        // Mixed handshake patterns with redirects, including one inside DRAIN
        do_reset();
        rsp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            req_ready      = (i % 3) != 2;
            inst_ready     = (i % 5) != 0;
            lat            = 1 + int'((i % 3) == 0);
            redirect_valid = (i == 20) || (i == 21) || (i == 41);
            redirect_pc    = (i == 20) ? 32'h0000_0040 :
                             (i == 21) ? 32'h0000_0083 : 32'h1234_5677;
            step();
        end
        redirect_valid = 1'b0;
        n0 = fire_log.size();
        chk("mixed_progress", 32'(n0 > 10), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
